// File: rtl/core_pkg.sv
// Shared state encoding and datapath select codes for the RV32I multi-cycle control sequencer.
package core_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5,
        ERR    = 3'd6
    } seq_state_e;

    // Plain-vector copies of the encoding so the FSM register stays a logic vector.
    localparam logic [2:0] ST_FETCH  = FETCH;
    localparam logic [2:0] ST_DECODE = DECODE;
    localparam logic [2:0] ST_EXEC   = EXEC;
    localparam logic [2:0] ST_MEM    = MEM;
    localparam logic [2:0] ST_WB     = WB;
    localparam logic [2:0] ST_HALT   = HALT;
    localparam logic [2:0] ST_ERR    = ERR;

    localparam logic [1:0] PC_SEL_PC4 = 2'd0;
    localparam logic [1:0] PC_SEL_IMM = 2'd1;
    localparam logic [1:0] PC_SEL_ALU = 2'd2;

    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_LOAD = 2'd1;
    localparam logic [1:0] WB_SEL_PC4  = 2'd2;

endpackage

// File: rtl/seq_timeout_cnt.sv
// Memory-wait watchdog: down-counter reloaded with TIMEOUT, decremented on each wait cycle,
// flagging the terminal count. TIMEOUT = 0 disables it.
module seq_timeout_cnt #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned    TW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]  LOAD_VAL = TW'(TIMEOUT);

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - TW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= LOAD_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Terminal count: the current wait cycle is the last one allowed.
    assign expire_o = (TIMEOUT != 0) && (cnt_q == TW'(1));

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the RV32I core, with
// halt-at-boundary, memory-wait timeout and a retired-instruction counter.
//
// state  | meaning
// FETCH  | imem request outstanding, IR loads on rvalid
// DECODE | regfile read cycle
// EXEC   | ALU operation; branches update PC and retire here
// MEM    | dmem request outstanding; stores retire on ack
// WB     | regfile write, PC update, retire
// HALT   | parked at an instruction boundary while halt_req_i is high
// ERR    | memory wait timed out; sticky until reset
module core_sequencer
    import core_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    output logic             imem_req_o,
    input  logic             imem_rvalid_i,
    output logic             dmem_req_o,
    output logic             dmem_we_o,
    input  logic             dmem_rvalid_i,
    input  logic             is_load_i,
    input  logic             is_S_i,
    input  logic             is_B_i,
    input  logic             is_J_i,
    input  logic             is_JALR_i,
    input  logic             is_LUI_i,
    input  logic             is_AUIPC_i,
    input  logic             br_taken_i,
    input  logic             halt_req_i,
    output logic             ir_we_o,
    output logic             pc_we_o,
    output logic [1:0]       pc_sel_o,
    output logic             opa_sel_o,
    output logic             rf_we_o,
    output logic [1:0]       wb_sel_o,
    output logic             retire_o,
    output logic [CNT_W-1:0] instr_cnt_o,
    output logic [2:0]       state_o,
    output logic             halted_o,
    output logic             err_o
);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
    logic             retire;
    logic             tmo_load, tmo_en, tmo_expire;

    // LUI needs no special sequencing: it goes EXEC -> WB like any ALU op.
    logic unused_lui;
    assign unused_lui = is_LUI_i;

    always_comb begin
        state_d    = state_q;
        imem_req_o = 1'b0;
        dmem_req_o = 1'b0;
        dmem_we_o  = 1'b0;
        ir_we_o    = 1'b0;
        pc_we_o    = 1'b0;
        pc_sel_o   = PC_SEL_PC4;
        opa_sel_o  = 1'b0;
        rf_we_o    = 1'b0;
        wb_sel_o   = WB_SEL_ALU;
        retire     = 1'b0;
        case (state_q)
            // Reset parks the FSM in FETCH; the request must stay low until rst_ni releases.
            ST_FETCH: if (rst_ni) begin
                imem_req_o = 1'b1;
                if (imem_rvalid_i) begin
                    ir_we_o = 1'b1;
                    state_d = ST_DECODE;
                end else if (tmo_expire) begin
                    state_d = ST_ERR;
                end
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                opa_sel_o = is_AUIPC_i | is_J_i | is_B_i;
                if (is_load_i | is_S_i) begin
                    state_d = ST_MEM;
                end else if (is_B_i) begin
                    pc_we_o  = 1'b1;
                    pc_sel_o = br_taken_i ? PC_SEL_IMM : PC_SEL_PC4;
                    retire   = 1'b1;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                dmem_req_o = 1'b1;
                dmem_we_o  = is_S_i;
                if (dmem_rvalid_i) begin
                    if (is_S_i) begin
                        pc_we_o = 1'b1;
                        retire  = 1'b1;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (tmo_expire) begin
                    state_d = ST_ERR;
                end
            end
            ST_WB: begin
                rf_we_o  = 1'b1;
                wb_sel_o = is_load_i ? WB_SEL_LOAD :
                           (is_J_i | is_JALR_i) ? WB_SEL_PC4 : WB_SEL_ALU;
                pc_we_o  = 1'b1;
                pc_sel_o = is_J_i ? PC_SEL_IMM : is_JALR_i ? PC_SEL_ALU : PC_SEL_PC4;
                retire   = 1'b1;
            end
            ST_HALT: if (!halt_req_i) state_d = ST_FETCH;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_ERR;
        endcase
        // Halt requests are only honoured at the retire boundary.
        if (retire) begin
            state_d = halt_req_i ? ST_HALT : ST_FETCH;
        end
    end

    assign instr_cnt_d = instr_cnt_q + CNT_W'(retire);

    assign tmo_load = (state_d != state_q);
    assign tmo_en   = ((state_q == ST_FETCH) && !imem_rvalid_i) ||
                      ((state_q == ST_MEM) && !dmem_rvalid_i);

    seq_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .load_i   (tmo_load),
        .en_i     (tmo_en),
        .expire_o (tmo_expire)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_FETCH;
            instr_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign retire_o    = retire;
    assign instr_cnt_o = instr_cnt_q;
    assign state_o     = state_q;
    assign halted_o    = (state_q == ST_HALT);
    assign err_o       = (state_q == ST_ERR);

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: instruction-level reference model expanded into
// per-cycle expectations, random instruction mix and latencies, plus directed corner cases.
module tb_core_sequencer;

    localparam int TO = 4;
    localparam int C_ADD = 0, C_LW = 1, C_SW = 2, C_BEQ = 3,
                   C_JAL = 4, C_JALR = 5, C_LUI = 6, C_AUIPC = 7;

    logic        clk_i = 1'b0, rst_ni = 1'b0;
    logic        imem_rvalid_i = 1'b0, dmem_rvalid_i = 1'b0;
    logic        is_load_i = 1'b0, is_S_i = 1'b0, is_B_i = 1'b0, is_J_i = 1'b0;
    logic        is_JALR_i = 1'b0, is_LUI_i = 1'b0, is_AUIPC_i = 1'b0;
    logic        br_taken_i = 1'b0, halt_req_i = 1'b0;
    logic        imem_req_o, dmem_req_o, dmem_we_o, ir_we_o, pc_we_o, opa_sel_o, rf_we_o;
    logic        retire_o, halted_o, err_o;
    logic [1:0]  pc_sel_o, wb_sel_o;
    logic [2:0]  state_o;
    logic [31:0] instr_cnt_o;

    core_sequencer #(.TIMEOUT(TO), .CNT_W(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .imem_req_o(imem_req_o), .imem_rvalid_i(imem_rvalid_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_rvalid_i(dmem_rvalid_i),
        .is_load_i(is_load_i), .is_S_i(is_S_i), .is_B_i(is_B_i), .is_J_i(is_J_i),
        .is_JALR_i(is_JALR_i), .is_LUI_i(is_LUI_i), .is_AUIPC_i(is_AUIPC_i),
        .br_taken_i(br_taken_i), .halt_req_i(halt_req_i),
        .ir_we_o(ir_we_o), .pc_we_o(pc_we_o), .pc_sel_o(pc_sel_o), .opa_sel_o(opa_sel_o),
        .rf_we_o(rf_we_o), .wb_sel_o(wb_sel_o), .retire_o(retire_o),
        .instr_cnt_o(instr_cnt_o), .state_o(state_o), .halted_o(halted_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          irv, drv;
        bit [6:0]    fl;      // {load, S, B, J, JALR, LUI, AUIPC}
        bit          br, hr;
        logic [16:0] exp;
    } cyc_t;

    cyc_t        q[$];
    int          checks = 0, errors = 0;
    logic [31:0] model_cnt = '0;
    bit          rel_pending = 1'b0;
    int          cyc_since_rst = 0, first_ret_cyc = -1;
    logic [31:0] cnt_at5 = '0;
    int          n_dreq, n_ireq, n_rfwe, n_ret, n_pcwe, n_wb2, n_opa, n_halted;

    // {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel[1:0], opa_sel, rf_we, wb_sel[1:0],
    //  retire, state[2:0], halted, err}
    function automatic logic [16:0] ov(input bit ireq, input bit dreq, input bit dwe,
                                       input bit irwe, input bit pcwe, input bit [1:0] pcs,
                                       input bit opa, input bit rfwe, input bit [1:0] wbs,
                                       input bit ret, input bit [2:0] st);
        return {ireq, dreq, dwe, irwe, pcwe, pcs, opa, rfwe, wbs, ret, st,
                st == 3'd5, st == 3'd6};
    endfunction

    function automatic logic [16:0] act();
        return {imem_req_o, dmem_req_o, dmem_we_o, ir_we_o, pc_we_o, pc_sel_o, opa_sel_o,
                rf_we_o, wb_sel_o, retire_o, state_o, halted_o, err_o};
    endfunction

    function automatic bit rb();
        return 1'($urandom);
    endfunction

    function automatic bit [6:0] rfl();
        return 7'($urandom);
    endfunction

    function automatic void push(input bit irv, input bit drv, input bit [6:0] fl,
                                 input bit br, input bit hr, input logic [16:0] e);
        cyc_t c;
        c.irv = irv; c.drv = drv; c.fl = fl; c.br = br; c.hr = hr; c.exp = e;
        q.push_back(c);
    endfunction

    function automatic void chk(input string name, input logic [31:0] got,
                                input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endfunction

    function automatic void gen_err(input int n);
        for (int i = 0; i < n; i++)
            push(rb(), rb(), rfl(), rb(), rb(), ov(0,0,0,0,0,2'd0,0,0,2'd0,0,3'd6));
    endfunction

    function automatic bit [6:0] flags_of(input int cls);
        case (cls)
            C_LW:    return 7'b1000000;
            C_SW:    return 7'b0100000;
            C_BEQ:   return 7'b0010000;
            C_JAL:   return 7'b0001000;
            C_JALR:  return 7'b0000100;
            C_LUI:   return 7'b0000010;
            C_AUIPC: return 7'b0000001;
            default: return 7'b0000000;
        endcase
    endfunction

    // One instruction: il/dl = cycles without rvalid (>= TO means timeout), hcyc < 0 = no halt.
    function automatic void gen_instr(input int cls, input int il, input int dl,
                                      input bit br, input int hcyc);
        bit [6:0] fl;
        bit       ld, is_s, b, j, jr, au, h, opa;
        bit [1:0] pcs, wbs;
        fl = flags_of(cls);
        ld = fl[6]; is_s = fl[5]; b = fl[4]; j = fl[3]; jr = fl[2]; au = fl[0];
        h   = (hcyc >= 0);
        opa = au | j | b;
        pcs = j ? 2'd1 : jr ? 2'd2 : 2'd0;
        wbs = ld ? 2'd1 : (j | jr) ? 2'd2 : 2'd0;
        for (int i = 0; i < il && i < TO; i++)
            push(0, rb(), rfl(), rb(), h | rb(), ov(1,0,0,0,0,2'd0,0,0,2'd0,0,3'd0));
        if (il >= TO) begin gen_err(8); return; end
        push(1, rb(), rfl(), rb(), h | rb(), ov(1,0,0,1,0,2'd0,0,0,2'd0,0,3'd0));
        push(rb(), rb(), fl, rb(), h | rb(), ov(0,0,0,0,0,2'd0,0,0,2'd0,0,3'd1));
        if (b) begin
            push(rb(), rb(), fl, br, h, ov(0,0,0,0,1,{1'b0, br},opa,0,2'd0,1,3'd2));
        end else begin
            push(rb(), rb(), fl, rb(), h | rb(), ov(0,0,0,0,0,2'd0,opa,0,2'd0,0,3'd2));
            if (ld | is_s) begin
                for (int i = 0; i < dl && i < TO; i++)
                    push(rb(), 0, fl, rb(), h | rb(), ov(0,1,is_s,0,0,2'd0,0,0,2'd0,0,3'd3));
                if (dl >= TO) begin gen_err(8); return; end
                if (is_s)
                    push(rb(), 1, fl, rb(), h, ov(0,1,1,0,1,2'd0,0,0,2'd0,1,3'd3));
                else
                    push(rb(), 1, fl, rb(), h | rb(), ov(0,1,0,0,0,2'd0,0,0,2'd0,0,3'd3));
            end
            if (!is_s)
                push(rb(), rb(), fl, rb(), h, ov(0,0,0,0,1,pcs,0,1,wbs,1,3'd4));
        end
        if (h) begin
            for (int i = 0; i < hcyc; i++)
                push(rb(), rb(), rfl(), rb(), 1, ov(0,0,0,0,0,2'd0,0,0,2'd0,0,3'd5));
            push(rb(), rb(), rfl(), rb(), 0, ov(0,0,0,0,0,2'd0,0,0,2'd0,0,3'd5));
        end
    endfunction

    function automatic void clear_tallies();
        n_dreq = 0; n_ireq = 0; n_rfwe = 0; n_ret = 0;
        n_pcwe = 0; n_wb2 = 0; n_opa = 0; n_halted = 0;
    endfunction

    task automatic run_queue();
        cyc_t        c;
        logic [16:0] a;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(posedge clk_i); #1;
            if (rel_pending) begin
                rst_ni = 1'b1; rel_pending = 1'b0; cyc_since_rst = 0;
            end else begin
                cyc_since_rst++;
            end
            imem_rvalid_i = c.irv;  dmem_rvalid_i = c.drv;
            is_load_i = c.fl[6]; is_S_i = c.fl[5]; is_B_i = c.fl[4]; is_J_i = c.fl[3];
            is_JALR_i = c.fl[2]; is_LUI_i = c.fl[1]; is_AUIPC_i = c.fl[0];
            br_taken_i = c.br;   halt_req_i = c.hr;
            @(negedge clk_i);
            a = act();
            checks++;
            if (a !== c.exp || instr_cnt_o !== model_cnt) begin
                errors++;
                $display("FAIL cycle %0d: outputs %h cnt %0d, expected %h cnt %0d",
                         cyc_since_rst, a, instr_cnt_o, c.exp, model_cnt);
            end
            if (retire_o && first_ret_cyc < 0) first_ret_cyc = cyc_since_rst;
            if (cyc_since_rst == 5) cnt_at5 = instr_cnt_o;
            n_dreq   += int'(dmem_req_o);
            n_ireq   += int'(imem_req_o);
            n_rfwe   += int'(rf_we_o);
            n_ret    += int'(retire_o);
            n_pcwe   += int'(pc_we_o);
            n_wb2    += int'(rf_we_o && wb_sel_o == 2'd2);
            n_opa    += int'(opa_sel_o);
            n_halted += int'(halted_o);
            if (c.exp[5]) model_cnt = model_cnt + 32'd1;
        end
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        #1;
        chk("rst_outs", {15'd0, act()}, 32'd0);
        chk("rst_cnt", instr_cnt_o, 32'd0);
        repeat (2) begin
            @(negedge clk_i);
            chk("rst_outs_hold", {15'd0, act()}, 32'd0);
        end
        model_cnt = '0; rel_pending = 1'b1; first_ret_cyc = -1; cyc_since_rst = 0;
    endtask

    initial begin
        do_reset();

        clear_tallies();
        gen_instr(C_ADD,   1, 0, 0, -1);
        gen_instr(C_LW,    0, 3, 0, -1);
        gen_instr(C_SW,    2, 0, 0, -1);
        gen_instr(C_BEQ,   0, 0, 1, -1);
        gen_instr(C_BEQ,   1, 0, 0, -1);
        gen_instr(C_JAL,   0, 0, 0, -1);
        gen_instr(C_JALR,  3, 0, 0, -1);   // rvalid in the last allowed cycle
        gen_instr(C_AUIPC, 0, 0, 0, -1);
        gen_instr(C_LUI,   0, 0, 0, -1);
        gen_instr(C_ADD,   0, 0, 0,  2);
        run_queue();
        chk("first_retire_cycle", first_ret_cyc, 32'd4);
        chk("cnt_after_first",    cnt_at5, 32'd1);
        chk("dir_retires",        n_ret, 32'd10);
        chk("dir_pc_we",          n_pcwe, 32'd10);
        chk("dir_rf_we",          n_rfwe, 32'd7);
        chk("dir_dmem_req_cyc",   n_dreq, 32'd5);
        chk("dir_imem_req_cyc",   n_ireq, 32'd17);
        chk("dir_wb_pc4",         n_wb2, 32'd2);
        chk("dir_opa_sel",        n_opa, 32'd4);
        chk("dir_halted_cyc",     n_halted, 32'd3);

        for (int i = 0; i < 60; i++)
            gen_instr($urandom_range(0, 7), $urandom_range(0, TO - 1),
                      $urandom_range(0, TO - 1), rb(),
                      ($urandom_range(0, 4) == 0) ? $urandom_range(0, 3) : -1);
        run_queue();

        gen_instr(C_SW, 0, TO, 0, -1);
        run_queue();
        chk("dmem_tmo_err_sticky", err_o, 32'd1);

        do_reset();
        clear_tallies();
        gen_instr(C_ADD, TO, 0, 0, -1);
        run_queue();
        chk("imem_tmo_req_cycles", n_ireq, 32'd4);
        chk("imem_tmo_err_sticky", err_o, 32'd1);

        do_reset();
        gen_instr(C_ADD, 0, 0, 0, -1);
        gen_instr(C_LW, 0, 3, 0, -1);
        repeat (3) void'(q.pop_back());
        run_queue();
        chk("pre_rst_dmem_req", dmem_req_o, 32'd1);
        do_reset();

        gen_instr(C_ADD, 0, 0, 0, -1);
        run_queue();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
